spi_flash_sequencer: RTL and testbench

- Sequences one SPI NOR flash transaction per accepted command: chip select, opcode, optional 24-bit address, dummy bytes, then a read or write data phase.
- Sits between the APB register/decode logic (command side) and the flash SPI pins.
- Generates SCK internally from p_clk.
- SPI mode 0, single-bit I/O, MSB first.

---
 rtl/spi_flash_sequencer_if.sv | 30 +++
 rtl/spi_flash_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_flash_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_sequencer_if.sv
// Command-side bundle between the APB decode logic (master) and the SPI flash sequencer (slave).
interface spi_flash_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic        cmd_has_addr;
  logic [23:0] cmd_addr;
  logic [3:0]  cmd_dummy;
  logic        cmd_write;
  logic [8:0]  cmd_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_opcode, cmd_has_addr, cmd_addr, cmd_dummy, cmd_write, cmd_len,
    output wr_data, wr_valid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_has_addr, cmd_addr, cmd_dummy, cmd_write, cmd_len,
    input  wr_data, wr_valid,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/spi_flash_sequencer.sv
// One SPI NOR transaction per command (mode 0, MSB first); write data stalls SCK low while wr_valid is low,
// read data has no backpressure. SCK is derived from p_clk, one bit = 2*CLK_DIV cycles.
module spi_flash_sequencer #(
  parameter int CLK_DIV = 2,
  parameter int CS_TIME = 2
) (
  input  logic                  p_clk,
  input  logic                  p_reset,
  spi_flash_sequencer_if.slave  cmd,
  output logic                  s_clk,
  output logic                  s_css,
  output logic                  s_mosi,
  input  logic                  s_miso
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = (CS_TIME > 1) ? $clog2(CS_TIME) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CS_LAST  = CW'(CS_TIME - 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, OPCODE, ADDR, DUMMY, DATA, CS_HOLD, CS_GAP
  } state_t;

  state_t          state;
  logic            ready_q, busy_q, done_q, wr_ready_q, rd_valid_q;
  logic [7:0]      rd_data_q;
  logic [7:0]      op_q;
  logic            has_addr_q;
  logic [23:0]     addr_q;
  logic [3:0]      dummy_q;
  logic            write_q;
  logic [8:0]      len_q;
  logic [7:0]      sh;
  logic [7:0]      rx;
  logic [DW-1:0]   div_cnt;
  logic [CW-1:0]   cs_cnt;
  logic [2:0]      bit_cnt;
  logic [8:0]      byte_cnt;
  logic            wr_wait;

  state_t          nx_state;
  logic [8:0]      nx_cnt;
  logic [7:0]      nx_byte;

  // Phase that follows `cur` once its last byte is out, skipping empty phases.
  function automatic state_t phase_after(state_t cur, logic has_addr, logic [3:0] dummy,
                                         logic [8:0] len);
    state_t nxt;
    nxt = CS_HOLD;
    if (cur == OPCODE && has_addr)
      nxt = ADDR;
    else if ((cur == OPCODE || cur == ADDR) && dummy != 4'd0)
      nxt = DUMMY;
    else if (cur != DATA && len != 9'd0)
      nxt = DATA;
    return nxt;
  endfunction

  always_comb begin
    nx_state = state;
    nx_cnt   = byte_cnt + 9'd1;
    case (state)
      OPCODE: begin
        nx_state = phase_after(OPCODE, has_addr_q, dummy_q, len_q);
        nx_cnt   = '0;
      end
      ADDR: if (byte_cnt == 9'd2) begin
        nx_state = phase_after(ADDR, has_addr_q, dummy_q, len_q);
        nx_cnt   = '0;
      end
      DUMMY: if (byte_cnt == {5'd0, dummy_q} - 9'd1) begin
        nx_state = phase_after(DUMMY, has_addr_q, dummy_q, len_q);
        nx_cnt   = '0;
      end
      DATA: if (byte_cnt == len_q - 9'd1) begin
        nx_state = CS_HOLD;
        nx_cnt   = '0;
      end
      default: ;
    endcase
    nx_byte = 8'h00;
    if (nx_state == ADDR) begin
      case (nx_cnt[1:0])
        2'd0:    nx_byte = addr_q[23:16];
        2'd1:    nx_byte = addr_q[15:8];
        default: nx_byte = addr_q[7:0];
      endcase
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      s_clk      <= 1'b0;
      s_css      <= 1'b1;
      s_mosi     <= 1'b0;
      op_q       <= 8'h00;
      has_addr_q <= 1'b0;
      addr_q     <= 24'h0;
      dummy_q    <= 4'h0;
      write_q    <= 1'b0;
      len_q      <= 9'h0;
      sh         <= 8'h00;
      rx         <= 8'h00;
      div_cnt    <= '0;
      cs_cnt     <= '0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 9'd0;
      wr_wait    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (cmd.cmd_valid && ready_q) begin
            op_q       <= cmd.cmd_opcode;
            has_addr_q <= cmd.cmd_has_addr;
            addr_q     <= cmd.cmd_addr;
            dummy_q    <= cmd.cmd_dummy;
            write_q    <= cmd.cmd_write;
            len_q      <= cmd.cmd_len;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            s_css      <= 1'b0;
            cs_cnt     <= '0;
            state      <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (cs_cnt == CS_LAST) begin
            state    <= OPCODE;
            sh       <= op_q;
            s_mosi   <= op_q[7];
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 9'd0;
          end else begin
            cs_cnt <= cs_cnt + 1'b1;
          end
        end
        OPCODE, ADDR, DUMMY, DATA: begin
          if (state == DATA && wr_wait) begin
            // Starved write: SCK parked low, counters frozen until a byte shows up.
            if (cmd.wr_valid) begin
              sh         <= cmd.wr_data;
              s_mosi     <= cmd.wr_data[7];
              wr_ready_q <= 1'b1;
              wr_wait    <= 1'b0;
              div_cnt    <= '0;
            end
          end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!s_clk) begin
              s_clk <= 1'b1;
              rx    <= {rx[6:0], s_miso};
            end else begin
              s_clk <= 1'b0;
              if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
                sh      <= {sh[6:0], 1'b0};
                s_mosi  <= sh[6];
              end else begin
                bit_cnt  <= 3'd0;
                state    <= nx_state;
                byte_cnt <= nx_cnt;
                cs_cnt   <= '0;
                if (state == DATA && !write_q) begin
                  rd_data_q  <= rx;
                  rd_valid_q <= 1'b1;
                end
                if (nx_state == DATA && write_q) begin
                  if (cmd.wr_valid) begin
                    sh         <= cmd.wr_data;
                    s_mosi     <= cmd.wr_data[7];
                    wr_ready_q <= 1'b1;
                  end else begin
                    s_mosi  <= 1'b0;
                    wr_wait <= 1'b1;
                  end
                end else begin
                  sh     <= nx_byte;
                  s_mosi <= nx_byte[7];
                end
              end
            end
          end
        end
        CS_HOLD: begin
          if (cs_cnt == CS_LAST) begin
            state  <= CS_GAP;
            s_css  <= 1'b1;
            cs_cnt <= '0;
          end else begin
            cs_cnt <= cs_cnt + 1'b1;
          end
        end
        CS_GAP: begin
          if (cs_cnt == CS_LAST) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cs_cnt <= cs_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign cmd.wr_ready  = wr_ready_q;
  assign cmd.rd_valid  = rd_valid_q;
  assign cmd.rd_data   = rd_data_q;
endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Directed bench for spi_flash_sequencer: WREN, READ, FAST_READ, PAGE PROGRAM with stall, and reset abort.
module tb_spi_flash_sequencer;
  logic p_clk = 1'b0;
  logic p_reset = 1'b1;
  logic s_clk, s_css, s_mosi;
  logic s_miso = 1'b0;

  spi_flash_sequencer_if bus();

  spi_flash_sequencer #(.CLK_DIV(2), .CS_TIME(2)) dut (
    .p_clk  (p_clk),
    .p_reset(p_reset),
    .cmd    (bus),
    .s_clk  (s_clk),
    .s_css  (s_css),
    .s_mosi (s_mosi),
    .s_miso (s_miso)
  );

  always #5 p_clk = ~p_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0, rise_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int css_low = 0, clk_viol = 0, css_rise_cyc = 0, done_cyc = 0;
  int miso_base = 1 << 30;
  logic css_prev = 1'b1;
  logic       mosi_log [0:1023];
  logic [7:0] rd_log   [0:15];
  int         rd_rise  [0:15];
  logic [7:0] miso_bytes [0:1];

  // Bus-side observer, sampled away from the active edge.
  always @(negedge p_clk) begin
    cyc++;
    if (bus.rd_valid === 1'b1) begin
      if (rd_cnt < 16) begin
        rd_log[rd_cnt]  = bus.rd_data;
        rd_rise[rd_cnt] = rise_cnt;
      end
      rd_cnt++;
    end
    if (bus.wr_ready === 1'b1) wr_cnt++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_css === 1'b0) css_low++;
    if (s_css === 1'b1 && s_clk === 1'b1) clk_viol++;
    if (s_css === 1'b1 && css_prev === 1'b0) css_rise_cyc = cyc;
    css_prev = s_css;
  end

  // Flash side: log MOSI on every SCK rise.
  always @(posedge s_clk) begin
    if (rise_cnt < 1024) mosi_log[rise_cnt] = s_mosi;
    rise_cnt++;
  end

  // Flash read model: presents the next bit after SCK falls, data starting at rise miso_base.
  always @(negedge s_clk or negedge s_css) begin : miso_model
    int k;
    k = rise_cnt - miso_base;
    if (k >= 0 && k < 16) s_miso = miso_bytes[k / 8][7 - (k % 8)];
    else s_miso = 1'b0;
  end

  function automatic logic [7:0] mbyte(input int idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], mosi_log[idx + i]};
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic has_addr, input logic [23:0] addr,
                       input logic [3:0] dummy, input logic wr, input logic [8:0] len);
    bus.cmd_opcode   = op;
    bus.cmd_has_addr = has_addr;
    bus.cmd_addr     = addr;
    bus.cmd_dummy    = dummy;
    bus.cmd_write    = wr;
    bus.cmd_len      = len;
    bus.cmd_valid    = 1'b1;
    @(negedge p_clk);
    bus.cmd_valid    = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge p_clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (3) @(negedge p_clk);
  endtask

  task automatic wait_rise(input int target, input string tag);
    int n;
    n = 0;
    while (rise_cnt < target && n < 3000) begin
      @(negedge p_clk);
      n++;
    end
    chk({tag, "_rise_reached"}, 32'(rise_cnt >= target), 32'd1);
  endtask

  task automatic wait_wr(input int target, input string tag);
    int n;
    n = 0;
    while (wr_cnt < target && n < 3000) begin
      @(negedge p_clk);
      n++;
    end
    chk({tag, "_wr_ready_seen"}, 32'(wr_cnt >= target), 32'd1);
  endtask

  initial begin
    int d0, r0, c0, w0, rc0, rs, viol;
    bus.cmd_valid = 1'b0;  bus.cmd_opcode = 8'h00; bus.cmd_has_addr = 1'b0;
    bus.cmd_addr  = 24'h0; bus.cmd_dummy  = 4'h0;  bus.cmd_write    = 1'b0;
    bus.cmd_len   = 9'h0;  bus.wr_data    = 8'h00; bus.wr_valid     = 1'b0;

    repeat (3) @(negedge p_clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_pins", {s_css, s_clk, s_mosi}, 3'b100);
    chk("rst_status", {bus.busy, bus.done, bus.rd_valid, bus.wr_ready}, 4'b0000);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    p_reset = 1'b0;

    viol = 0;
    repeat (10) begin
      @(negedge p_clk);
      if (s_css !== 1'b1 || s_clk !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) viol++;
    end
    chk("idle_window", viol, 0);

    // WREN: 2 setup + 8 bits * 4 + 2 hold cycles with CS low.
    d0 = done_cnt; r0 = rise_cnt; c0 = css_low;
    issue(8'h06, 1'b0, 24'h0, 4'd0, 1'b0, 9'd0);
    wait_done(d0, "wren");
    chk("wren_css_low", css_low - c0, 36);
    chk("wren_rises", rise_cnt - r0, 8);
    chk("wren_mosi", mbyte(r0), 8'h06);
    chk("wren_done_gap", done_cyc - css_rise_cyc, 2);
    chk("wren_done_cnt", done_cnt - d0, 1);

    // READ: opcode + 3 address bytes = 32 rises, then 2 data bytes.
    miso_bytes[0] = 8'hA5; miso_bytes[1] = 8'h3C;
    d0 = done_cnt; r0 = rise_cnt; rc0 = rd_cnt;
    miso_base = r0 + 32;
    issue(8'h03, 1'b1, 24'h123456, 4'd0, 1'b0, 9'd2);
    wait_done(d0, "read");
    chk("read_mosi", {mbyte(r0), mbyte(r0 + 8), mbyte(r0 + 16), mbyte(r0 + 24)}, 32'h03123456);
    chk("read_rises", rise_cnt - r0, 48);
    chk("read_rd_cnt", rd_cnt - rc0, 2);
    chk("read_byte0", rd_log[rc0], 8'hA5);
    chk("read_byte1", rd_log[rc0 + 1], 8'h3C);
    chk("read_first_rd_rise", rd_rise[rc0] - r0, 40);
    chk("read_done_cnt", done_cnt - d0, 1);

    // FAST_READ: 8 + 24 + 8 dummy = 40 rises before data.
    miso_bytes[0] = 8'h5A;
    d0 = done_cnt; r0 = rise_cnt; rc0 = rd_cnt;
    miso_base = r0 + 40;
    issue(8'h0B, 1'b1, 24'h000100, 4'd1, 1'b0, 9'd1);
    wait_done(d0, "fast");
    chk("fast_mosi", {mbyte(r0), mbyte(r0 + 8), mbyte(r0 + 16), mbyte(r0 + 24)}, 32'h0B000100);
    chk("fast_dummy_mosi", mbyte(r0 + 32), 8'h00);
    chk("fast_rises", rise_cnt - r0, 48);
    chk("fast_rd_cnt", rd_cnt - rc0, 1);
    chk("fast_byte", rd_log[rc0], 8'h5A);
    chk("fast_rd_rise", rd_rise[rc0] - r0, 48);

    // PAGE PROGRAM with the second byte withheld long enough to stall SCK.
    miso_base = 1 << 30;
    d0 = done_cnt; r0 = rise_cnt; w0 = wr_cnt;
    bus.wr_data = 8'h11; bus.wr_valid = 1'b1;
    issue(8'h02, 1'b1, 24'h00ABCD, 4'd0, 1'b1, 9'd3);
    wait_wr(w0 + 1, "pp_b0");
    bus.wr_valid = 1'b0; bus.wr_data = 8'h22;
    wait_rise(r0 + 40, "pp_b0_out");
    repeat (4) @(negedge p_clk);
    rs = rise_cnt; viol = 0;
    repeat (20) begin
      @(negedge p_clk);
      if (s_clk !== 1'b0 || s_css !== 1'b0) viol++;
    end
    chk("pp_stall_pins", viol, 0);
    chk("pp_stall_rises", rise_cnt - rs, 0);
    chk("pp_stall_wr_cnt", wr_cnt - w0, 1);
    bus.wr_valid = 1'b1;
    wait_wr(w0 + 2, "pp_b1");
    bus.wr_data = 8'h33;
    wait_wr(w0 + 3, "pp_b2");
    bus.wr_valid = 1'b0;
    wait_done(d0, "pp");
    chk("pp_wr_ready_cnt", wr_cnt - w0, 3);
    chk("pp_rises", rise_cnt - r0, 56);
    chk("pp_hdr_mosi", {mbyte(r0), mbyte(r0 + 8), mbyte(r0 + 16), mbyte(r0 + 24)}, 32'h0200ABCD);
    chk("pp_data_mosi", {8'h00, mbyte(r0 + 32), mbyte(r0 + 40), mbyte(r0 + 48)}, 32'h00112233);

    // Reset in the middle of a read's address phase.
    miso_bytes[0] = 8'hFF; miso_bytes[1] = 8'hFF;
    d0 = done_cnt; r0 = rise_cnt; rc0 = rd_cnt;
    miso_base = r0 + 32;
    issue(8'h03, 1'b1, 24'h654321, 4'd0, 1'b0, 9'd2);
    wait_rise(r0 + 12, "abort");
    p_reset = 1'b1;
    @(negedge p_clk);
    chk("abort_pins", {s_css, s_clk}, 2'b10);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 0);
    p_reset = 1'b0;
    repeat (5) @(negedge p_clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_rd", rd_cnt - rc0, 0);
    chk("abort_ready_back", bus.cmd_ready, 1);

    miso_base = 1 << 30;
    d0 = done_cnt; r0 = rise_cnt;
    issue(8'h06, 1'b0, 24'h0, 4'd0, 1'b0, 9'd0);
    wait_done(d0, "wren2");
    chk("wren2_mosi", mbyte(r0), 8'h06);
    chk("wren2_rises", rise_cnt - r0, 8);
    chk("wren2_done_cnt", done_cnt - d0, 1);

    chk("sck_while_deselected", clk_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
